// File: rtl/ram_port_arbiter.sv
// Shares the data RAM port between the CPU load/store path and a debug read channel.
// Optional stall counter is built only when ARB_STALL_COUNT_EN is defined.
module ram_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_mode,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_mode,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       stall_count
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  // The cycle that reaches this count is itself a lost cycle, so the grant
  // follows after exactly STARVE_MAX CPU-busy cycles.
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_mode  = cpu_mode;
    ram_we    = cpu_req & cpu_we;
    cpu_rdata = ram_rdata;
    cpu_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg_req && (!cpu_req || starve_q >= STARVE_LAST)) begin
          state_d = GRANT;
        end else if (dbg_req && cpu_req) begin
          starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end else begin
          starve_d = '0;
        end
      end
      GRANT: begin
        ram_addr  = dbg_addr;
        ram_wdata = '0;
        ram_mode  = 2'b10;
        ram_we    = 1'b0;
        cpu_rdata = '0;
        cpu_stall = cpu_req;
        starve_d  = '0;
        state_d   = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        starve_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      dbg_ack_q <= (state_q == GRANT);
      if (state_q == GRANT) dbg_rdata_q <= ram_rdata;
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

`ifdef ARB_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stall_cnt_q <= '0;
    end else if (cpu_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic
// checked every cycle against an event-level model of the port sharing rules.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int SMAX   = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic              cpu_req, cpu_we;
  logic [1:0]        cpu_mode;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [1:0]        ram_mode;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [31:0]       stall_count;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_cmp = 0;
  int n_bad = 0;

  // model of the expected per-cycle behaviour
  bit          m_debug_cycle;   // this cycle the debug channel holds the port
  bit          m_ack_cycle;     // this cycle the debug data is presented
  int          m_lost;          // CPU-busy cycles the pending request has lost
  logic [31:0] m_rdata;
  logic [31:0] m_stalls;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .clr(clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mode(ram_mode), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_sc(input logic [31:0] n);
`ifdef ARB_STALL_COUNT_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  // model update and RAM write on each clock edge
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_debug_cycle = 0;
      m_ack_cycle   = 0;
      m_lost        = 0;
      m_rdata       = '0;
      m_stalls      = '0;
    end else begin
      if (m_debug_cycle) begin
        m_rdata       = mem[dbg_addr];
        if (cpu_req && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        m_debug_cycle = 0;
        m_ack_cycle   = 1;
        m_lost        = 0;
      end else if (m_ack_cycle) begin
        m_ack_cycle = 0;
      end else if (dbg_req) begin
        if (!cpu_req) begin
          m_debug_cycle = 1;
        end else begin
          m_lost++;
          if (m_lost >= SMAX) m_debug_cycle = 1;
        end
      end else begin
        m_lost = 0;
      end
      if (ram_we) mem[ram_addr] = ram_wdata;
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (m_debug_cycle) begin
      chk("ram_addr", ram_addr, dbg_addr);
      chk("ram_we", ram_we, 1'b0);
      chk("ram_mode", ram_mode, 2'b10);
      chk("ram_wdata", ram_wdata, 32'h0);
      chk("cpu_stall", cpu_stall, cpu_req);
      chk("cpu_rdata", cpu_rdata, 32'h0);
    end else begin
      chk("ram_addr", ram_addr, cpu_addr);
      chk("ram_we", ram_we, cpu_req & cpu_we);
      chk("ram_mode", ram_mode, cpu_mode);
      chk("ram_wdata", ram_wdata, cpu_wdata);
      chk("cpu_stall", cpu_stall, 1'b0);
      chk("cpu_rdata", cpu_rdata, mem[cpu_addr]);
    end
    chk("dbg_ack", dbg_ack, m_ack_cycle);
    chk("dbg_rdata", dbg_rdata, m_rdata);
    chk("stall_count", stall_count, exp_sc(m_stalls));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    cpu_req = 0; cpu_we = 0; dbg_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] ack_seen;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = $urandom;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h020] = 32'hAAAA5555;
    clr = 0; cpu_req = 0; cpu_we = 0; cpu_mode = 2'b10; cpu_addr = 12'h030;
    cpu_wdata = 0; dbg_req = 0; dbg_addr = 0;

    // reset state
    step(); step();
    @(negedge clk);
    chk("reset dbg_ack", dbg_ack, 1'b0);
    chk("reset dbg_rdata", dbg_rdata, 32'h0);
    chk("reset stall_count", stall_count, 32'h0);
    #2 clr = 1;
    idle_cycles(2);

    // uncontended read: cycle 0 request, cycle 1 grant, cycle 2 ack
    dbg_req = 1; dbg_addr = 12'h010;
    step();
    @(negedge clk);
    chk("uncont grant ram_addr", ram_addr, 12'h010);
    chk("uncont cpu_stall", cpu_stall, 1'b0);
    step();
    dbg_req = 0;
    @(negedge clk);
    chk("uncont dbg_ack", dbg_ack, 1'b1);
    chk("uncont dbg_rdata", dbg_rdata, 32'hDEADBEEF);
    idle_cycles(3);

    // forced grant with the CPU busy every cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h030; dbg_req = 1; dbg_addr = 12'h010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("forced early cpu_stall", cpu_stall, 1'b0);
      chk("forced early ram_addr", ram_addr, 12'h030);
      step();
    end
    cpu_we = 1; cpu_addr = 12'h020; cpu_wdata = 32'h12345678;
    @(negedge clk);
    chk("forced grant cpu_stall", cpu_stall, 1'b1);
    chk("forced grant ram_we", ram_we, 1'b0);
    step();
    dbg_req = 0;
    @(negedge clk);
    chk("forced dbg_ack", dbg_ack, 1'b1);
    chk("forced stall_count", stall_count, exp_sc(32'd1));
    chk("store held off", mem[12'h020], 32'hAAAA5555);
    step();
    @(negedge clk);
    chk("store after stall", mem[12'h020], 32'h12345678);
    idle_cycles(3);

    // back-to-back reads
    dbg_req = 1; dbg_addr = 12'h010; ack_seen = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      ack_seen[c] = dbg_ack;
      step();
    end
    dbg_req = 0;
    chk("b2b ack pattern", ack_seen, 9'b100100100);
    idle_cycles(3);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1);
      cpu_mode  = 2'($urandom_range(0, 3));
      cpu_addr  = 12'($urandom);
      cpu_wdata = $urandom;
      if (dbg_req && dbg_ack) dbg_req = 0;
      else if (dbg_req && $urandom_range(0, 31) == 0) dbg_req = 0;
      else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1; dbg_addr = 12'($urandom);
      end
    end
    idle_cycles(4);

    // reset during the grant cycle aborts the access
    dbg_req = 1; dbg_addr = 12'h010; cpu_addr = 12'h040;
    step();
    clr = 0;
    dbg_req = 0;
    @(negedge clk);
    chk("rst grant dbg_ack", dbg_ack, 1'b0);
    chk("rst grant dbg_rdata", dbg_rdata, 32'h0);
    chk("rst grant stall_count", stall_count, 32'h0);
    chk("rst grant ram_addr", ram_addr, 12'h040);
    #2 clr = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      chk("rst no late ack", dbg_ack, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
